div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative radix-2 multi-cycle divider for DIV/DIVU.
- Sits in EX; it is the producer for the HI/LO register file.
- Drives remainder on the HI write data, quotient on the LO write data, and a 2-bit HI/LO write-enable (bit1 = HI, bit0 = LO) for one cycle at completion.
- Exposes busy so the pipeline controller can stall EX while a division is in flight.

Parameters:
- WIDTH, 32, operand/result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  request a division; sampled only in IDLE.
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU; latched at accept.
- opdata1  in  WIDTH  dividend; latched at accept.
- opdata2  in  WIDTH  divisor; latched at accept.
- annul  in  1  abort an in-flight division (exception/flush).
- busy  out  1  high in every state except IDLE.
- ready  out  1  one-cycle completion pulse.
- hilo_we  out  2  {HI we, LO we}; 2'b11 exactly when ready = 1, else 2'b00.
- result_hi  out  WIDTH  remainder; held until the next accepted start.
- result_lo  out  WIDTH  quotient; held until the next accepted start.

Behaviour:
- Reset (resetn = 0, async): state IDLE, busy = 0, ready = 0, hilo_we = 0, result_hi = result_lo = 0, counter = 0. Reset mid-operation discards all work.
- States:
  - IDLE: if start && !annul, latch operands and go to DIVZERO when opdata2 == 0, else go to ON with counter = 0. Otherwise stay in IDLE.
  - DIVZERO: one cycle, then go to END with quotient = all-ones, remainder = dividend (raw, unsigned and signed alike).
  - ON: one shift-subtract step per cycle on magnitudes. After step WIDTH-1 (counter == WIDTH-1), go to END. Counter increments by 1 per ON cycle.
  - END: ready = 1, hilo_we = 2'b11, result_* updated and visible this cycle. Next state is IDLE.
- Latency: start accepted at edge T gives ready high during cycle T+WIDTH+1 (T+33 for WIDTH = 32). For a zero divisor, ready is high at T+2.
- Signed mode:
  - Take absolute values at accept.
  - Quotient is negated iff the operand signs differ.
  - Remainder takes the sign of the dividend (|r| < |divisor|).
  - 0x80000000 / 0xFFFFFFFF gives q = 0x80000000, r = 0. This wraps with no trap.
- Unsigned mode: operands are used as-is; no negation.
- Step arithmetic:
  - Partial remainder is WIDTH+1 bits.
  - Each step: shift left, bringing in the next dividend bit from the MSB side.
  - Trial-subtract the divisor. If the result is non-negative, keep it and set quotient bit = 1; else quotient bit = 0.
- annul:
  - In DIVZERO, ON or END, go to IDLE next cycle. ready and hilo_we stay 0 in that annul cycle, even in END (annul masks the outputs combinationally).
  - result_* are not updated.
  - In IDLE, annul blocks acceptance of a simultaneous start.
- start while busy: ignored; latched operands do not change.
- start in the same cycle as END: not accepted. A new start is accepted only in IDLE, so back-to-back accepts are at least WIDTH+2 cycles apart.
- Operand inputs may change freely after the accept edge.

Decomposition:
- Shared package (cpu_defs):
  - state encodings DIV_IDLE = 2'd0, DIV_DIVZERO = 2'd1, DIV_ON = 2'd2, DIV_END = 2'd3;
  - HILO_WE_BOTH = 2'b11, HILO_WE_NONE = 2'b00.
- One natural sub-module: div_step.
  - Combinational, one shift-subtract iteration.
  - Inputs: partial remainder, divisor, next dividend bit.
  - Outputs: new partial remainder, quotient bit.
  - Instantiated once in div_unit.

Test Plan:
- Unsigned: start, signed_div = 0, 100 / 7 → ready at T+33, result_lo = 14, result_hi = 2, hilo_we = 2'b11 for one cycle only; busy high T+1..T+33.
- Signed: 0xFFFFFFF9 (-7) / 2 → result_lo = 0xFFFFFFFD, result_hi = 0xFFFFFFFF. Then 7 / 0xFFFFFFFE → q = 0xFFFFFFFD, r = 1.
- Divide by zero: 0x12345678 / 0 (both signed modes) → ready at T+2, result_lo = 0xFFFFFFFF, result_hi = 0x12345678.
- Overflow: signed 0x80000000 / 0xFFFFFFFF → q = 0x80000000, r = 0. Unsigned 0xFFFFFFFF / 1 → q = 0xFFFFFFFF, r = 0.
- annul at T+10 (also repeat during END): no ready, hilo_we stays 0, result_* keep prior values, busy = 0 next cycle. A start during busy is ignored and the original result completes at T+33.
- resetn pulsed low asynchronously mid-ON (no clock edge) → all outputs 0 immediately. The next start 10 / 3 completes normally with q = 3, r = 1.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared definitions for the EX-stage divider and the HI/LO write port.
// Holds the divider state encoding and the HI/LO write-enable codes.
package cpu_defs;

    typedef enum logic [1:0] {
        DIV_IDLE    = 2'd0,
        DIV_DIVZERO = 2'd1,
        DIV_ON      = 2'd2,
        DIV_END     = 2'd3
    } div_state_e;

    localparam logic [1:0] HILO_WE_BOTH = 2'b11;
    localparam logic [1:0] HILO_WE_NONE = 2'b00;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration: shift in a dividend bit and
// trial-subtract the divisor from the widened partial remainder.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             bit_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_o
);

    logic [WIDTH+1:0] shifted_s;
    logic [WIDTH+1:0] diff_s;

    // Trial subtraction; the extra top bit of diff_s acts as the borrow/sign.
    always_comb begin
        shifted_s = {rem_i, bit_i};
        diff_s    = shifted_s - {2'b00, divisor_i};
        if (diff_s[WIDTH+1] == 1'b0) begin
            rem_o = diff_s[WIDTH:0];
            q_o   = 1'b1;
        end else begin
            rem_o = shifted_s[WIDTH:0];
            q_o   = 1'b0;
        end
    end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 DIV/DIVU unit feeding the HI/LO register file.
// Works on magnitudes and fixes up signs when the final step completes.
module div_unit
    import cpu_defs::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] opdata1,
    input  logic [WIDTH-1:0] opdata2,
    input  logic             annul,
    output logic             busy,
    output logic             ready,
    output logic [1:0]       hilo_we,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] raw_q, raw_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic [WIDTH-1:0] fin_hi_q, fin_hi_d;
    logic [WIDTH-1:0] fin_lo_q, fin_lo_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d;

    logic [WIDTH:0]   step_rem_s;
    logic             step_q_s;
    logic [WIDTH-1:0] quo_next_s;

    // quo_q doubles as the dividend shift register: its MSB feeds the step
    // while quotient bits enter from the LSB side.
    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .divisor_i (dsr_q),
        .bit_i     (quo_q[WIDTH-1]),
        .rem_o     (step_rem_s),
        .q_o       (step_q_s)
    );

    assign quo_next_s = {quo_q[WIDTH-2:0], step_q_s};

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dsr_d    = dsr_q;
        raw_d    = raw_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        fin_hi_d = fin_hi_q;
        fin_lo_d = fin_lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        case (state_q)
            DIV_IDLE: begin
                if (start && !annul) begin
                    raw_d  = opdata1;
                    negq_d = signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
                    negr_d = signed_div & opdata1[WIDTH-1];
                    quo_d  = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
                    dsr_d  = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;
                    rem_d  = '0;
                    cnt_d  = '0;
                    if (opdata2 == '0) begin
                        state_d = DIV_DIVZERO;
                    end else begin
                        state_d = DIV_ON;
                    end
                end else begin
                    state_d = DIV_IDLE;
                end
            end
            DIV_DIVZERO: begin
                if (annul) begin
                    state_d = DIV_IDLE;
                end else begin
                    fin_lo_d = '1;
                    fin_hi_d = raw_q;
                    state_d  = DIV_END;
                end
            end
            DIV_ON: begin
                if (annul) begin
                    state_d = DIV_IDLE;
                end else begin
                    rem_d = step_rem_s;
                    quo_d = quo_next_s;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_STEP) begin
                        fin_lo_d = negq_q ? -quo_next_s : quo_next_s;
                        fin_hi_d = negr_q ? -step_rem_s[WIDTH-1:0] : step_rem_s[WIDTH-1:0];
                        state_d  = DIV_END;
                    end else begin
                        state_d = DIV_ON;
                    end
                end
            end
            DIV_END: begin
                state_d = DIV_IDLE;
                if (!annul) begin
                    res_hi_d = fin_hi_q;
                    res_lo_d = fin_lo_q;
                end else begin
                    res_hi_d = res_hi_q;
                    res_lo_d = res_lo_q;
                end
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= DIV_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dsr_q    <= '0;
            raw_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            fin_hi_q <= '0;
            fin_lo_q <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dsr_q    <= dsr_d;
            raw_q    <= raw_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            fin_hi_q <= fin_hi_d;
            fin_lo_q <= fin_lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
        end
    end

    // An annul in END masks completion, so the new result only shows when it commits.
    always_comb begin
        busy  = (state_q != DIV_IDLE);
        ready = (state_q == DIV_END) && !annul;
        if (ready) begin
            hilo_we   = HILO_WE_BOTH;
            result_hi = fin_hi_q;
            result_lo = fin_lo_q;
        end else begin
            hilo_we   = HILO_WE_NONE;
            result_hi = res_hi_q;
            result_lo = res_lo_q;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed corner cases plus random divisions
// checked against an arithmetic reference model.
module tb_div_unit;

    logic        clk;
    logic        resetn;
    logic        start;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        annul;
    logic        busy;
    logic        ready;
    logic [1:0]  hilo_we;
    logic [31:0] result_hi;
    logic [31:0] result_lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec;
    int          n_fail;
    int          cyc;
    logic [31:0] last_hi;
    logic [31:0] last_lo;

    div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .annul      (annul),
        .busy       (busy),
        .ready      (ready),
        .hilo_we    (hilo_we),
        .result_hi  (result_hi),
        .result_lo  (result_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain integer division, truncating toward zero in signed mode.
    function automatic void model(input logic sg, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
        longint sa;
        longint sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (busy) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    // annul_at < 0: normal completion; otherwise annul that many cycles after accept.
    task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                           input int annul_at, input bit busy_start);
        logic [31:0] q;
        logic [31:0] r;
        exp_t        e;
        wait_idle();
        @(negedge clk);
        start      = 1'b1;
        signed_div = sg;
        opdata1    = a;
        opdata2    = b;
        model(sg, a, b, q, r);
        e.hi  = r;
        e.lo  = q;
        e.acc = cyc + 1;
        e.lat = (b == 32'd0) ? 1 : 32;
        if (annul_at < 0) exp_q.push_back(e);
        @(negedge clk);
        start      = 1'b0;
        opdata1    = $urandom;
        opdata2    = $urandom;
        signed_div = 1'($urandom);
        check("busy_after_accept", 32'(busy), 32'd1);
        if (busy_start) begin
            @(negedge clk);
            start   = 1'b1;
            opdata1 = $urandom;
            opdata2 = $urandom_range(1, 9);
            @(negedge clk);
            start = 1'b0;
        end
        if (annul_at >= 0) begin
            while ((cyc - e.acc) < annul_at) @(negedge clk);
            annul = 1'b1;
            #1;
            check("annul_ready", 32'(ready), 32'd0);
            check("annul_hilo_we", 32'(hilo_we), 32'd0);
            @(negedge clk);
            annul = 1'b0;
            #1;
            check("annul_busy", 32'(busy), 32'd0);
            check("annul_hold_hi", result_hi, last_hi);
            check("annul_hold_lo", result_lo, last_lo);
        end
        wait_idle();
    endtask

    // Monitor: pops the scoreboard whenever the DUT signals completion.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (resetn) begin
                if (ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_ready", 32'(ready), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("result_hi", result_hi, e.hi);
                        check("result_lo", result_lo, e.lo);
                        check("hilo_we_done", 32'(hilo_we), 32'd3);
                        check("latency", 32'(cyc - e.acc), 32'(e.lat));
                        last_hi = e.hi;
                        last_lo = e.lo;
                    end
                end else if (hilo_we !== 2'b00) begin
                    check("hilo_we_idle", 32'(hilo_we), 32'd0);
                end
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic        sg;
        int          guard;
        n_vec      = 0;
        n_fail     = 0;
        cyc        = 0;
        last_hi    = 32'd0;
        last_lo    = 32'd0;
        resetn     = 1'b0;
        start      = 1'b0;
        signed_div = 1'b0;
        opdata1    = 32'd0;
        opdata2    = 32'd0;
        annul      = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_hilo_we", 32'(hilo_we), 32'd0);
        check("rst_hi", result_hi, 32'd0);
        check("rst_lo", result_lo, 32'd0);
        resetn = 1'b1;

        run_div(1'b0, 32'd100, 32'd7, -1, 1'b0);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, -1, 1'b0);
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, -1, 1'b0);
        run_div(1'b0, 32'h1234_5678, 32'd0, -1, 1'b0);
        run_div(1'b1, 32'h1234_5678, 32'd0, -1, 1'b0);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, -1, 1'b0);
        run_div(1'b0, 32'd5000, 32'd3, 10, 1'b0);
        run_div(1'b0, 32'd5000, 32'd3, 32, 1'b0);
        run_div(1'b1, 32'hCAFE_0001, 32'd0, 1, 1'b0);
        run_div(1'b0, 32'd99, 32'd10, -1, 1'b1);

        // Asynchronous reset in the middle of an iteration, away from any edge.
        wait_idle();
        @(negedge clk);
        start      = 1'b1;
        signed_div = 1'b0;
        opdata1    = 32'd100;
        opdata2    = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #1 resetn = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_ready", 32'(ready), 32'd0);
        check("arst_hilo_we", 32'(hilo_we), 32'd0);
        check("arst_hi", result_hi, 32'd0);
        check("arst_lo", result_lo, 32'd0);
        last_hi = 32'd0;
        last_lo = 32'd0;
        #1 resetn = 1'b1;
        run_div(1'b0, 32'd10, 32'd3, -1, 1'b0);

        for (int i = 0; i < 30; i++) begin
            sg = 1'($urandom);
            a  = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3:       b = 32'($urandom) >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            run_div(sg, a, b, -1, 1'b0);
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
